// File: rtl/peripherals_obi_arbiter_if.sv
// OBI bus bundle shared by the arbiter's initiator-facing and target-facing ports.
// master drives request/rready, slave drives grant/response.
interface peripherals_obi_arbiter_if #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned IDW = 1
);
    logic            req;
    logic            reqpar;
    logic [AW-1:0]   addr;
    logic            we;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
    logic [IDW-1:0]  aid;
    logic            gnt;
    logic            gntpar;
    logic            rvalid;
    logic            rvalidpar;
    logic            rready;
    logic            rreadypar;
    logic [DW-1:0]   rdata;
    logic            err;
    logic [IDW-1:0]  rid;

    modport master (
        output req, reqpar, addr, we, be, wdata, aid, rready, rreadypar,
        input  gnt, gntpar, rvalid, rvalidpar, rdata, err, rid
    );

    modport slave (
        input  req, reqpar, addr, we, be, wdata, aid, rready, rreadypar,
        output gnt, gntpar, rvalid, rvalidpar, rdata, err, rid
    );
endinterface

// File: rtl/peripherals_obi_arbiter.sv
// Two-initiator round-robin OBI arbiter with a single outstanding transaction and a
// response-timeout watchdog that answers with an error and then drains the late response.
module peripherals_obi_arbiter #(
    parameter int unsigned       OBI_AW         = 32,
    parameter int unsigned       OBI_DW         = 32,
    parameter int unsigned       OBI_IDW        = 1,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [OBI_DW-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    peripherals_obi_arbiter_if.slave    s0,
    peripherals_obi_arbiter_if.slave    s1,
    peripherals_obi_arbiter_if.master   m,
    output logic                        timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast =
        CntW'(TIMEOUT_CYCLES == 0 ? 32'd0 : TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax = '1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAddr   = 3'd1;
    localparam logic [2:0] StResp   = 3'd2;
    localparam logic [2:0] StErrRsp = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic               own_q, own_d;   // 0 = s0, 1 = s1
    logic               ptr_q, ptr_d;
    logic [OBI_IDW-1:0] aid_q, aid_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic                st_addr, st_resp, st_err, st_drain;
    logic                own_req, own_reqpar, own_we, own_rready;
    logic [OBI_AW-1:0]   own_addr;
    logic [OBI_DW/8-1:0] own_be;
    logic [OBI_DW-1:0]   own_wdata;
    logic [OBI_IDW-1:0]  own_aid;

    logic                gnt_fwd, m_rready, rsp_valid, rsp_err;
    logic [OBI_DW-1:0]   rsp_rdata;
    logic [OBI_IDW-1:0]  rsp_rid;
    logic                s0_gnt, s1_gnt, s0_rvalid, s1_rvalid;
    logic                unused_par;

    assign st_addr  = (state_q == StAddr);
    assign st_resp  = (state_q == StResp);
    assign st_err   = (state_q == StErrRsp);
    assign st_drain = (state_q == StDrain);

    assign own_req    = own_q ? s1.req    : s0.req;
    assign own_reqpar = own_q ? s1.reqpar : s0.reqpar;
    assign own_addr   = own_q ? s1.addr   : s0.addr;
    assign own_we     = own_q ? s1.we     : s0.we;
    assign own_be     = own_q ? s1.be     : s0.be;
    assign own_wdata  = own_q ? s1.wdata  : s0.wdata;
    assign own_aid    = own_q ? s1.aid    : s0.aid;
    assign own_rready = own_q ? s1.rready : s0.rready;

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        aid_d     = aid_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (s0.req | s1.req) begin
                    own_d   = (s0.req & s1.req) ? ptr_q : s1.req;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (own_req & m.gnt) begin
                    aid_d   = own_aid;
                    cnt_d   = '0;
                    ptr_d   = ~own_q;
                    state_d = StResp;
                end
            end
            StResp: begin
                // A real response arriving in the expiry cycle takes priority.
                if (m.rvalid & own_rready) begin
                    state_d = StIdle;
                end else if (TIMEOUT_CYCLES != 0 && !m.rvalid) begin
                    if (cnt_q == CntLast) begin
                        state_d   = StErrRsp;
                        timeout_d = 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StErrRsp: begin
                if (own_rready) state_d = StDrain;
            end
            StDrain: begin
                if (m.rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            own_q     <= 1'b0;
            ptr_q     <= 1'b0;
            aid_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            aid_q     <= aid_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

    // Target-facing request side is only driven while an owner is in its address phase.
    assign m.req       = st_addr & own_req;
    assign m.reqpar    = st_addr ? own_reqpar : 1'b1;
    assign m.addr      = st_addr ? own_addr   : '0;
    assign m.we        = st_addr & own_we;
    assign m.be        = st_addr ? own_be     : '0;
    assign m.wdata     = st_addr ? own_wdata  : '0;
    assign m.aid       = st_addr ? own_aid    : '0;
    assign m_rready    = (st_resp & own_rready) | st_drain;
    assign m.rready    = m_rready;
    assign m.rreadypar = ~m_rready;

    assign gnt_fwd   = st_addr & m.gnt;
    assign rsp_valid = (st_resp & m.rvalid) | st_err;
    assign rsp_err   = (st_resp & m.err) | st_err;
    assign rsp_rdata = st_err ? ERR_RDATA : (st_resp ? m.rdata : '0);
    assign rsp_rid   = st_err ? aid_q     : (st_resp ? m.rid   : '0);

    assign s0_gnt    = gnt_fwd & ~own_q;
    assign s1_gnt    = gnt_fwd & own_q;
    assign s0_rvalid = rsp_valid & ~own_q;
    assign s1_rvalid = rsp_valid & own_q;

    assign s0.gnt       = s0_gnt;
    assign s0.gntpar    = ~s0_gnt;
    assign s0.rvalid    = s0_rvalid;
    assign s0.rvalidpar = ~s0_rvalid;
    assign s0.rdata     = own_q ? '0 : rsp_rdata;
    assign s0.err       = rsp_err & ~own_q;
    assign s0.rid       = own_q ? '0 : rsp_rid;

    assign s1.gnt       = s1_gnt;
    assign s1.gntpar    = ~s1_gnt;
    assign s1.rvalid    = s1_rvalid;
    assign s1.rvalidpar = ~s1_rvalid;
    assign s1.rdata     = own_q ? rsp_rdata : '0;
    assign s1.err       = rsp_err & own_q;
    assign s1.rid       = own_q ? rsp_rid : '0;

    // Incoming parities are accepted but not checked.
    assign unused_par = ^{m.gntpar, m.rvalidpar, s0.rreadypar, s1.rreadypar};

endmodule

// File: tb/tb_peripherals_obi_arbiter.sv
// Directed bench for peripherals_obi_arbiter: vector table for simple transactions plus
// hand-written sequences for round-robin, watchdog, expiry race and mid-transaction reset.
module tb_peripherals_obi_arbiter;

    logic clk;
    logic reset_n;
    logic timeout;
    int   total = 0;
    int   bad   = 0;

    peripherals_obi_arbiter_if #(.AW(32), .DW(32), .IDW(1)) s0_if ();
    peripherals_obi_arbiter_if #(.AW(32), .DW(32), .IDW(1)) s1_if ();
    peripherals_obi_arbiter_if #(.AW(32), .DW(32), .IDW(1)) m_if ();

    peripherals_obi_arbiter #(
        .OBI_AW        (32),
        .OBI_DW        (32),
        .OBI_IDW       (1),
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s0       (s0_if),
        .s1       (s1_if),
        .m        (m_if),
        .timeout_o(timeout)
    );

    assign s0_if.reqpar    = ~s0_if.req;
    assign s0_if.rreadypar = ~s0_if.rready;
    assign s1_if.reqpar    = ~s1_if.req;
    assign s1_if.rreadypar = ~s1_if.rready;
    assign m_if.gntpar     = ~m_if.gnt;
    assign m_if.rvalidpar  = ~m_if.rvalid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {s0_req, s1_req, m_gnt, m_rvalid}
    // exp = {s0_gnt, s1_gnt, m_req, s0_rvalid, s1_rvalid, m_rready}
    typedef struct {
        logic [3:0]  in;
        logic [31:0] rd;
        logic [5:0]  exp;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_we;
    logic        cur_aid;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_if.req = 1'b0;
        s1_if.req = 1'b0;
        m_if.gnt = 1'b0;
        m_if.rvalid = 1'b0;
        m_if.rdata = 32'h0;
        m_if.err = 1'b0;
        m_if.rid = 1'b0;
        s0_if.rready = 1'b1;
        s1_if.rready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #7;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic run_rows(input int lo, input int hi, input int exp_reqs);
        int nreq = 0;
        for (int i = lo; i < hi; i++) begin
            s0_if.req   = vecs[i].in[3];
            s1_if.req   = vecs[i].in[2];
            m_if.gnt    = vecs[i].in[1];
            m_if.rvalid = vecs[i].in[0];
            m_if.rdata  = vecs[i].rd;
            m_if.rid    = cur_aid;
            @(negedge clk);
            chk1("s0_gnt", s0_if.gnt, vecs[i].exp[5]);
            chk1("s1_gnt", s1_if.gnt, vecs[i].exp[4]);
            chk1("m_req", m_if.req, vecs[i].exp[3]);
            chk1("s0_rvalid", s0_if.rvalid, vecs[i].exp[2]);
            chk1("s1_rvalid", s1_if.rvalid, vecs[i].exp[1]);
            chk1("m_rready", m_if.rready, vecs[i].exp[0]);
            chk1("m_reqpar", m_if.reqpar, ~vecs[i].exp[3]);
            if (m_if.req) nreq++;
            if (vecs[i].exp[3]) begin
                chk32("m_addr", m_if.addr, cur_addr);
                chk32("m_wdata", m_if.wdata, cur_wdata);
                chk1("m_we", m_if.we, cur_we);
                chk1("m_aid", m_if.aid, cur_aid);
            end
            if (vecs[i].exp[2]) begin
                chk32("s0_rdata", s0_if.rdata, vecs[i].rd);
                chk1("s0_err", s0_if.err, 1'b0);
                chk1("s0_rid", s0_if.rid, cur_aid);
            end
            if (vecs[i].exp[1]) begin
                chk32("s1_rdata", s1_if.rdata, vecs[i].rd);
                chk1("s1_rid", s1_if.rid, cur_aid);
            end
            tick();
        end
        chk32("m_req_count", 32'(nreq), 32'(exp_reqs));
    endtask

    initial begin
        logic eo;
        vecs[0]  = '{4'b1010, 32'h0,         6'b000000};
        vecs[1]  = '{4'b1010, 32'h0,         6'b101000};
        vecs[2]  = '{4'b0000, 32'h0,         6'b000001};
        vecs[3]  = '{4'b0001, 32'h0000_1111, 6'b000101};
        vecs[4]  = '{4'b0000, 32'h0,         6'b000000};
        vecs[5]  = '{4'b0100, 32'h0,         6'b000000};
        vecs[6]  = '{4'b0110, 32'h0,         6'b011000};
        vecs[7]  = '{4'b0101, 32'h2000_0001, 6'b000011};
        vecs[8]  = '{4'b0100, 32'h0,         6'b000000};
        vecs[9]  = '{4'b0110, 32'h0,         6'b011000};
        vecs[10] = '{4'b0101, 32'h2000_0002, 6'b000011};
        vecs[11] = '{4'b0100, 32'h0,         6'b000000};
        vecs[12] = '{4'b0110, 32'h0,         6'b011000};
        vecs[13] = '{4'b0001, 32'h2000_0003, 6'b000011};
        vecs[14] = '{4'b0000, 32'h0,         6'b000000};

        s0_if.addr = 32'h0103_0100; s0_if.wdata = 32'hA5A5_A5A5; s0_if.we = 1'b1;
        s0_if.be = 4'hF; s0_if.aid = 1'b0;
        s1_if.addr = 32'h0103_0200; s1_if.wdata = 32'h0; s1_if.we = 1'b0;
        s1_if.be = 4'hF; s1_if.aid = 1'b1;
        idle_inputs();

        // Reset values while reset is held
        reset_n = 1'b0;
        #3;
        chk1("rst_m_req", m_if.req, 1'b0);
        chk1("rst_m_reqpar", m_if.reqpar, 1'b1);
        chk1("rst_m_rready", m_if.rready, 1'b0);
        chk1("rst_m_rreadypar", m_if.rreadypar, 1'b1);
        chk32("rst_m_addr", m_if.addr, 32'h0);
        chk32("rst_m_wdata", m_if.wdata, 32'h0);
        chk1("rst_s0_gnt", s0_if.gnt, 1'b0);
        chk1("rst_s0_gntpar", s0_if.gntpar, 1'b1);
        chk1("rst_s1_rvalidpar", s1_if.rvalidpar, 1'b1);
        chk32("rst_s0_rdata", s0_if.rdata, 32'h0);
        chk1("rst_timeout", timeout, 1'b0);
        do_reset();

        // s0 write, rvalid two cycles after gnt
        cur_addr = 32'h0103_0100; cur_wdata = 32'hA5A5_A5A5; cur_we = 1'b1; cur_aid = 1'b0;
        run_rows(0, 5, 1);

        // s1 alone after reset, three reads
        do_reset();
        cur_addr = 32'h0103_0200; cur_wdata = 32'h0; cur_we = 1'b0; cur_aid = 1'b1;
        run_rows(5, 15, 3);

        // Both request continuously: strict alternation starting at s0
        do_reset();
        s0_if.aid = 1'b0; s1_if.aid = 1'b1;
        s0_if.req = 1'b1; s1_if.req = 1'b1; m_if.gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            eo = k[0];
            m_if.rvalid = 1'b0;
            @(negedge clk);
            chk1("rr_idle_s0_gnt", s0_if.gnt, 1'b0);
            chk1("rr_idle_s1_gnt", s1_if.gnt, 1'b0);
            tick();
            @(negedge clk);
            chk1("rr_s0_gnt", s0_if.gnt, ~eo);
            chk1("rr_s1_gnt", s1_if.gnt, eo);
            chk1("rr_m_aid", m_if.aid, eo);
            chk32("rr_m_addr", m_if.addr, eo ? 32'h0103_0200 : 32'h0103_0100);
            tick();
            m_if.rvalid = 1'b1; m_if.rdata = 32'h3000_0000 + 32'(k); m_if.rid = eo;
            @(negedge clk);
            chk1("rr_s0_rvalid", s0_if.rvalid, ~eo);
            chk1("rr_s1_rvalid", s1_if.rvalid, eo);
            chk1("rr_busy_gnt", s0_if.gnt | s1_if.gnt, 1'b0);
            chk32("rr_rdata", eo ? s1_if.rdata : s0_if.rdata, 32'h3000_0000 + 32'(k));
            chk1("rr_rid", eo ? s1_if.rid : s0_if.rid, eo);
            tick();
        end

        // Watchdog expiry, error response, drain of late response
        do_reset();
        s0_if.aid = 1'b1; s0_if.req = 1'b1; m_if.gnt = 1'b1;
        tick();
        @(negedge clk);
        chk1("to_s0_gnt", s0_if.gnt, 1'b1);
        tick();
        s0_if.req = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk1("to_wait_rvalid", s0_if.rvalid, 1'b0);
            chk1("to_wait_timeout", timeout, 1'b0);
            chk1("to_wait_rready", m_if.rready, 1'b1);
            if (j == 8) s0_if.rready = 1'b0;
            tick();
        end
        @(negedge clk);
        chk1("to_err_rvalid", s0_if.rvalid, 1'b1);
        chk1("to_err_err", s0_if.err, 1'b1);
        chk32("to_err_rdata", s0_if.rdata, 32'hDEAD_BEEF);
        chk1("to_err_rid", s0_if.rid, 1'b1);
        chk1("to_pulse", timeout, 1'b1);
        chk1("to_err_mrready", m_if.rready, 1'b0);
        chk1("to_err_s1_rvalid", s1_if.rvalid, 1'b0);
        tick();
        s0_if.rready = 1'b1;
        @(negedge clk);
        chk1("to_err_hold_rvalid", s0_if.rvalid, 1'b1);
        chk1("to_pulse_end", timeout, 1'b0);
        tick();
        s0_if.req = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            m_if.rvalid = (j == 20); m_if.rdata = 32'h5555_AAAA;
            @(negedge clk);
            chk1("drain_mrready", m_if.rready, 1'b1);
            chk1("drain_s0_rvalid", s0_if.rvalid, 1'b0);
            chk1("drain_s0_gnt", s0_if.gnt, 1'b0);
            tick();
        end
        m_if.rvalid = 1'b0;
        @(negedge clk);
        chk1("post_idle_gnt", s0_if.gnt, 1'b0);
        tick();
        @(negedge clk);
        chk1("post_gnt", s0_if.gnt, 1'b1);
        tick();
        s0_if.req = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_600D; m_if.rid = 1'b1;
        @(negedge clk);
        chk1("post_rvalid", s0_if.rvalid, 1'b1);
        chk1("post_err", s0_if.err, 1'b0);
        chk32("post_rdata", s0_if.rdata, 32'h0000_600D);
        tick();

        // Response in the exact expiry cycle wins over the watchdog
        do_reset();
        s0_if.aid = 1'b0; s0_if.req = 1'b1; m_if.gnt = 1'b1;
        tick();
        tick();
        s0_if.req = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            chk1("race_wait_rvalid", s0_if.rvalid, 1'b0);
            tick();
        end
        m_if.rvalid = 1'b1; m_if.rdata = 32'hCAFE_F00D; m_if.err = 1'b0; m_if.rid = 1'b0;
        @(negedge clk);
        chk1("race_rvalid", s0_if.rvalid, 1'b1);
        chk1("race_err", s0_if.err, 1'b0);
        chk32("race_rdata", s0_if.rdata, 32'hCAFE_F00D);
        chk1("race_timeout", timeout, 1'b0);
        tick();
        m_if.rvalid = 1'b0;
        @(negedge clk);
        chk1("race_no_pulse", timeout, 1'b0);
        chk1("race_idle_rvalid", s0_if.rvalid, 1'b0);
        tick();

        // Asynchronous reset while a response is outstanding
        do_reset();
        s0_if.req = 1'b1; s1_if.req = 1'b1; m_if.gnt = 1'b1;
        tick();
        tick();
        s0_if.req = 1'b0;
        #2;
        chk1("ar_pre_rready", m_if.rready, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("ar_m_rready", m_if.rready, 1'b0);
        chk1("ar_m_rreadypar", m_if.rreadypar, 1'b1);
        chk1("ar_m_req", m_if.req, 1'b0);
        chk1("ar_s1_gnt", s1_if.gnt, 1'b0);
        chk1("ar_s0_gntpar", s0_if.gntpar, 1'b1);
        m_if.rvalid = 1'b1; m_if.rdata = 32'h7777_7777;
        #1;
        chk1("ar_s0_rvalid", s0_if.rvalid, 1'b0);
        chk32("ar_s0_rdata", s0_if.rdata, 32'h0);
        @(negedge clk);
        m_if.rvalid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk1("ar_rel_s1_gnt0", s1_if.gnt, 1'b0);
        tick();
        @(negedge clk);
        chk1("ar_rel_s1_gnt1", s1_if.gnt, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
